// File: rtl/snake_body_engine.sv
// ============================================================================
// snake_body_engine
// ----------------------------------------------------------------------------
// Keeps the snake's body as a MAX_LEN-entry coordinate store and drives it
// out as two packed buses for the VGA display path. A `step` pulse moves the
// head one tile in the resolved direction. The body then shifts one entry
// per cycle from the tail end toward the head. The block also handles growth
// on food, detects wall and self collisions, and keeps `score` and a sticky
// `game_done`. Empty slots hold all-ones (-1), which the display treats as
// "no segment".
//
// Optional feature macro: SNAKE_WRAP_EN
//   defined   : an off-grid head wraps to the opposite edge; only self
//               collision ends the game.
//   undefined : an off-grid head ends the game at COMMIT.
//
// Ports
//   clk        in   system clock (single domain)
//   reset      in   synchronous, active-high reset
//   step       in   one-cycle move request (accepted only in IDLE, game live)
//   dir        in   0=up (y-1), 1=right (x+1), 2=down (y+1), 3=left (x-1)
//   food_x/y   in   food tile coordinate, sampled on the acceptance cycle
//   x_values   out  slot j at [32j +: 32], slot 0 is the head
//   y_values   out  same layout as x_values
//   length     out  occupied slots
//   score      out  food eaten (wraps at 2^32)
//   ate        out  one-cycle pulse after a COMMIT that ate food
//   busy       out  high while a move is in progress
//   game_done  out  sticky game-over flag, cleared only by reset
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for an accepted step
//   ST_SHIFT  | slot[idx] <- slot[idx-1], idx counts MAX_LEN-1 down to 1
//   ST_COMMIT | write new head, fix tail/length/score, latch game over
// ============================================================================
module snake_body_engine #(
    parameter int MAX_LEN = 100,
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 10,
    parameter int START_X = 5,
    parameter int START_Y = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic [1:0]             dir,
    input  logic [31:0]            food_x,
    input  logic [31:0]            food_y,
    output logic [32*MAX_LEN-1:0]  x_values,
    output logic [32*MAX_LEN-1:0]  y_values,
    output logic [31:0]            length,
    output logic [31:0]            score,
    output logic                   ate,
    output logic                   busy,
    output logic                   game_done
);

    localparam int                 IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(MAX_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
    localparam logic [31:0]        LEN_MAX = 32'(MAX_LEN);
    localparam logic signed [31:0] GW_S    = GRID_W;
    localparam logic signed [31:0] GH_S    = GRID_H;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      x_slot [MAX_LEN];
    logic [31:0]      y_slot [MAX_LEN];

    logic [1:0]       cur_dir;
    logic [31:0]      head_x, head_y;
    logic             grow, wall, hit;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic [1:0]       dir_res;
    logic [31:0]      raw_x, raw_y, new_x, new_y;
    logic             new_wall;
    logic [IDX_W-1:0] idx_m1;
    logic [31:0]      hit_lim;
    logic             shift_match;

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar j = 0; j < MAX_LEN; j++) begin : g_pack
        assign x_values[32*j +: 32] = x_slot[j];
        assign y_values[32*j +: 32] = y_slot[j];
    end

    // ------------------------------------------------------------------
    // Direction resolution and candidate head
    // ------------------------------------------------------------------
    always_comb begin
        dir_res = dir;
        // A reversal into the neck is refused once there is a neck.
        if ((length > 32'd1) && (dir == (cur_dir ^ 2'b10)))
            dir_res = cur_dir;

        raw_x = x_slot[0];
        raw_y = y_slot[0];
        case (dir_res)
            2'd0:    raw_y = y_slot[0] - 32'd1;
            2'd1:    raw_x = x_slot[0] + 32'd1;
            2'd2:    raw_y = y_slot[0] + 32'd1;
            default: raw_x = x_slot[0] - 32'd1;
        endcase

`ifdef SNAKE_WRAP_EN
        // The head moves at most one tile, so it can only overshoot by one.
        new_x = raw_x;
        new_y = raw_y;
        if ($signed(raw_x) < 0)
            new_x = 32'(GW_S - 1);
        else if ($signed(raw_x) >= GW_S)
            new_x = 32'd0;
        if ($signed(raw_y) < 0)
            new_y = 32'(GH_S - 1);
        else if ($signed(raw_y) >= GH_S)
            new_y = 32'd0;
        new_wall = 1'b0;
`else
        new_x    = raw_x;
        new_y    = raw_y;
        new_wall = ($signed(raw_x) < 0) || ($signed(raw_x) >= GW_S) ||
                   ($signed(raw_y) < 0) || ($signed(raw_y) >= GH_S);
`endif
    end

    // ------------------------------------------------------------------
    // Self-collision compare against the slot about to be shifted.
    // Without growth the old tail slot (length-1) vacates, so it is excluded.
    // ------------------------------------------------------------------
    always_comb begin
        idx_m1      = idx - IDX_ONE;
        hit_lim     = length - 32'd1 + {31'd0, grow};
        shift_match = (x_slot[idx_m1] == head_x) &&
                      (y_slot[idx_m1] == head_y) &&
                      ({{(32-IDX_W){1'b0}}, idx_m1} < hit_lim);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (step && !game_done) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (idx == IDX_ONE)
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                x_slot[IDX_W'(k)] <= (k == 0) ? 32'(START_X) : '1;
                y_slot[IDX_W'(k)] <= (k == 0) ? 32'(START_Y) : '1;
            end
            length    <= 32'd1;
            score     <= 32'd0;
            ate       <= 1'b0;
            game_done <= 1'b0;
            cur_dir   <= 2'd1;
            head_x    <= 32'd0;
            head_y    <= 32'd0;
            grow      <= 1'b0;
            wall      <= 1'b0;
            hit       <= 1'b0;
            idx       <= IDX_TOP;
        end else begin
            ate <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_dir <= dir_res;
                        head_x  <= new_x;
                        head_y  <= new_y;
                        grow    <= (new_x == food_x) && (new_y == food_y);
                        wall    <= new_wall;
                        hit     <= 1'b0;
                        idx     <= IDX_TOP;
                    end
                end
                ST_SHIFT: begin
                    x_slot[idx] <= x_slot[idx_m1];
                    y_slot[idx] <= y_slot[idx_m1];
                    if (shift_match)
                        hit <= 1'b1;
                    idx <= idx_m1;
                end
                ST_COMMIT: begin
                    // Head is written even on a collision so the frozen
                    // frame shows where the snake died.
                    x_slot[0] <= head_x;
                    y_slot[0] <= head_y;
                    if (!grow) begin
                        // At full length the old tail already fell off the end.
                        if (length < LEN_MAX) begin
                            x_slot[length[IDX_W-1:0]] <= '1;
                            y_slot[length[IDX_W-1:0]] <= '1;
                        end
                    end else begin
                        score <= score + 32'd1;
                        ate   <= 1'b1;
                        if (length < LEN_MAX) begin
                            length <= length + 32'd1;
                        end else begin
                            x_slot[IDX_TOP] <= '1;
                            y_slot[IDX_TOP] <= '1;
                        end
                    end
                    if (wall || hit)
                        game_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Producer of the packed snake-position buses consumed by the VGA display path. On each `step` pulse, the block moves the head one tile in the latched direction. It shifts the body serially, one entry per cycle, through a 100-entry coordinate store, and handles growth on food. It detects wall and self collisions, and maintains `score` and a sticky `game_done`. Unused slots read as all-ones (−1), the empty-slot encoding the display expects.

## Interface
Parameters:
- `MAX_LEN`, 100: number of body slots; bus width is 32·MAX_LEN.
- `GRID_W`, 10: tiles per row; legal x is 0..GRID_W−1.
- `GRID_H`, 10: tiles per column; legal y is 0..GRID_H−1.
- `START_X`, 5: head x after reset.
- `START_Y`, 5: head y after reset.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: synchronous, active-high.
- `step` input 1: one-cycle move request.
- `dir` input 2: requested direction. 0=up (y−1), 1=right (x+1), 2=down (y+1), 3=left (x−1).
- `food_x` input 32: food tile x.
- `food_y` input 32: food tile y.
- `x_values` output 32·MAX_LEN: slot j at bits [32j +: 32]; slot 0 is the head.
- `y_values` output 32·MAX_LEN: same layout as `x_values`.
- `length` output 32: occupied slots.
- `score` output 32: food eaten.
- `ate` output 1: one-cycle pulse when food is eaten.
- `busy` output 1: high while a move is in progress.
- `game_done` output 1: sticky game-over flag.

## Operation
- Reset values:
  - Slot 0 = (START_X, START_Y); all other slots 32'hFFFF_FFFF.
  - `length`=1, `score`=0; `ate`, `busy`, `game_done` = 0.
  - Current direction = right; state IDLE.
- States: IDLE → SHIFT → COMMIT → IDLE.
- IDLE: `step` is accepted only when `game_done`=0. On acceptance:
  - Resolve the direction. If `length`>1 and `dir` is the exact opposite of the current direction, keep the current direction; otherwise adopt `dir`.
  - Compute the new head: signed 32-bit add of ±1 to slot 0.
  - Latch the new head. Set `grow` = (new head == (`food_x`, `food_y`)).
  - Set `wall` = (new x outside 0..GRID_W−1) or (new y outside 0..GRID_H−1).
  - Load index i = MAX_LEN−1.
- SHIFT, one cycle per i, from i = MAX_LEN−1 down to 1:
  - Write slot[i] ← slot[i−1].
  - In the same cycle, compare the latched head with the pre-shift slot[i−1]. If they match and i−1 < `length`−1+`grow`, set `hit`. With no growth the old tail slot is excluded, since it vacates.
- COMMIT:
  - Write slot 0 ← new head.
  - If `grow`=0: slot[`length`] ← −1 (clears the shifted old tail).
  - If `grow`=1: `length` saturating +1 at MAX_LEN; when saturated, clear slot[MAX_LEN−1] instead. `score`+1 (wraps at 2^32). `ate`=1.
  - If `wall` or `hit`: `game_done`=1. The head is still written, so the frozen frame shows the collision.
- `game_done` remains set until `reset`. All `step` pulses are ignored while it is set.
- Food placement is owned elsewhere; this block only compares against it.

## Timing
- Step accepted at edge T:
  - `busy`=1 from T+1 through T+MAX_LEN (MAX_LEN−1 SHIFT cycles + 1 COMMIT cycle).
  - `busy`=0 at T+MAX_LEN+1.
- At COMMIT (edge T+MAX_LEN), `ate` pulses and `length`, `score`, `game_done` update, all visible together at T+MAX_LEN+1.
- `step` while `busy`=1 is dropped and not queued.
- `dir`, `food_x`, `food_y` are sampled only on the acceptance cycle.
- Buses change during SHIFT, so intermediate frames may show a duplicated segment. The display tolerates this; a move completes in about 1 µs, well under one frame.
- Reset overrides everything: it wins over a simultaneous `step` and aborts SHIFT or COMMIT mid-move, returning to the reset state on the next edge.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - An out-of-range head wraps: x=−1→GRID_W−1, x=GRID_W→0; same for y.
  - `wall` is never set; only self collision ends the game.
- `SNAKE_WRAP_EN` undefined: any out-of-range head sets `game_done` at COMMIT.

## Test plan
- Reset check → slot0=(5,5), slots 1..99 = FFFF_FFFF, `length`=1, `score`=0, `busy`=0, `game_done`=0.
- `step`, `dir`=1, food at (0,0) → `busy` high exactly 100 cycles; slot0=(6,5); slot1=−1; `ate` never pulses.
- Food at (6,5), `step`, `dir`=1 → slot0=(6,5), slot1=(5,5), `length`=2, `score`=1, single-cycle `ate` at COMMIT.
- `length`=2 heading right, `step`, `dir`=3 → move continues right, no reversal. Separately, `step` pulses during `busy` → ignored, single move only.
- Head at (9,5), `step`, `dir`=1:
  - Without `SNAKE_WRAP_EN` → `game_done`=1; later steps ignored.
  - With `SNAKE_WRAP_EN` → head (0,5), `game_done`=0.
- Self collision: grow to `length`=5, then steps up, left, down, right → head enters a body slot, `game_done`=1. Then `reset` mid-SHIFT on a fresh move → reset state on the next cycle.
